// File: rtl/wave_capture_buffer.sv
// Trigger-armed capture buffer: waits for a phase match, stores a fixed window of
// samples in RAM while tracking min/max, and exposes the window via a registered read port.
module wave_capture_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    sample_valid,
    input  logic [DATA_WIDTH-1:0]   sample_in,
    input  logic [ADDR_WIDTH-1:0]   phase_in,
    input  logic [ADDR_WIDTH-1:0]   trig_phase,
    input  logic                    rd_en,
    input  logic [DEPTH_LOG2-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic [DEPTH_LOG2:0]     wr_count,
    output logic [DATA_WIDTH-1:0]   min_val,
    output logic [DATA_WIDTH-1:0]   max_val
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  wr_en;
    logic                  win_clear;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, write strobe and window-clear decode; abort outranks everything
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        win_clear  = 1'b0;
        wr_addr    = wr_count[DEPTH_LOG2-1:0];
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_next = S_ARMED;
                        win_clear  = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (sample_valid && (phase_in == trig_phase)) begin
                        state_next = S_CAPTURE;
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid) begin
                        wr_en = 1'b1;
                        if (wr_count == CW'(DEPTH - 1)) begin
                            state_next = S_DONE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Status flags follow the state being entered so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_ARMED) || (state_next == S_CAPTURE);
            done <= (state_next == S_DONE);
        end
    end

    // Window count and running min/max; partial values survive abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            min_val  <= '1;
            max_val  <= '0;
        end else if (win_clear) begin
            wr_count <= '0;
            min_val  <= '1;
            max_val  <= '0;
        end else if (wr_en) begin
            wr_count <= wr_count + CW'(1);
            if (sample_in < min_val) begin
                min_val <= sample_in;
            end
            if (sample_in > max_val) begin
                max_val <= sample_in;
            end
        end
    end

    // Capture RAM, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= sample_in;
        end
    end

    // Registered read; same-edge write is not yet visible, giving read-before-write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Randomized bench for wave_capture_buffer: behavioural window model plus literal checks
// for the directed capture scenarios.
module tb_wave_capture_buffer;

    localparam int DEPTH = 64;
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_in = '0;
    logic [9:0] phase_in = '0;
    logic [9:0] trig_phase = '0;
    logic       rd_en = 1'b0;
    logic [5:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic [6:0] wr_count;
    logic [7:0] min_val;
    logic [7:0] max_val;

    wave_capture_buffer dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .sample_valid(sample_valid), .sample_in(sample_in), .phase_in(phase_in),
        .trig_phase(trig_phase), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .wr_count(wr_count), .min_val(min_val), .max_val(max_val)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model of the capture window
    int m_state = M_IDLE;
    int m_cnt = 0, m_min = 255, m_max = 0, m_rd_data = 0;
    bit m_rd_valid = 1'b0, m_rd_known = 1'b1, m_wr;
    int m_ram [DEPTH];
    bit m_known [DEPTH];

    int ph = 0;
    bit last_v = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = M_IDLE; m_cnt = 0; m_min = 255; m_max = 0;
            m_rd_data = 0; m_rd_valid = 1'b0; m_rd_known = 1'b1;
        end else begin
            m_wr = 1'b0;
            m_rd_valid = rd_en;
            if (rd_en) begin
                m_rd_data  = m_ram[rd_addr];
                m_rd_known = m_known[rd_addr];
            end
            if (abort) m_state = M_IDLE;
            else if (arm && (m_state == M_IDLE || m_state == M_DONE)) begin
                m_state = M_ARMED; m_cnt = 0; m_min = 255; m_max = 0;
            end else if (m_state == M_ARMED && sample_valid && phase_in == trig_phase) begin
                m_state = M_CAPT; m_wr = 1'b1;
            end else if (m_state == M_CAPT && sample_valid) m_wr = 1'b1;
            if (m_wr) begin
                m_ram[m_cnt] = int'(sample_in);
                m_known[m_cnt] = 1'b1;
                m_cnt++;
                if (int'(sample_in) < m_min) m_min = int'(sample_in);
                if (int'(sample_in) > m_max) m_max = int'(sample_in);
                if (m_cnt == DEPTH) m_state = M_DONE;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(m_state == M_ARMED || m_state == M_CAPT));
            chk("done", int'(done), int'(m_state == M_DONE));
            chk("wr_count", int'(wr_count), m_cnt);
            chk("min_val", int'(min_val), m_min);
            chk("max_val", int'(max_val), m_max);
            chk("rd_valid", int'(rd_valid), int'(m_rd_valid));
            if (m_rd_known) chk("rd_data", int'(rd_data), m_rd_data);
        end
    end

    task automatic set_ph(input int p);
        ph = p;
        last_v = 1'b0;
    endtask

    task automatic pulse(input bit a, input bit ab);
        @(negedge clk);
        sample_valid = 1'b0; rd_en = 1'b0; arm = a; abort = ab;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
    endtask

    // Feed the phase stream; stop on done (stop_cnt<0) or when wr_count hits stop_cnt
    task automatic run(input int vmode, input int rmode, input bit rnd_data,
                       input int stop_cnt, input int budget, output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            if (last_v) ph = (ph + 1) % 1024;
            case (vmode)
                0: sample_valid = 1'b1;
                1: sample_valid = (cycles % 2 == 0);
                default: sample_valid = 1'($urandom_range(0, 1));
            endcase
            phase_in  = 10'(ph);
            sample_in = rnd_data ? 8'($urandom) : 8'(ph);
            last_v = sample_valid;
            case (rmode)
                0: rd_en = 1'b0;
                1: begin rd_en = 1'($urandom_range(0, 1)); rd_addr = 6'($urandom); end
                default: begin rd_en = 1'b1; rd_addr = 6'(m_cnt); end
            endcase
            @(posedge clk);
            #1;
            cycles++;
            if (stop_cnt < 0 ? (done === 1'b1) : (int'(wr_count) == stop_cnt)) break;
            if (cycles >= budget) begin
                n_vec++; n_err++;
                $display("FAIL run_budget: got %0d cycles without stop condition, required < %0d", cycles, budget);
                break;
            end
        end
        @(negedge clk);
        sample_valid = 1'b0; rd_en = 1'b0;
    endtask

    task automatic read_check(input int addr, input int exp);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 6'(addr);
        @(negedge clk);
        rd_en = 1'b0;
        chk($sformatf("rd_valid_at_%0d", addr), int'(rd_valid), 1);
        chk($sformatf("rd_data_at_%0d", addr), int'(rd_data), exp);
        @(negedge clk);
        chk("rd_valid_drop", int'(rd_valid), 0);
        chk("rd_data_hold", int'(rd_data), exp);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_count", int'(wr_count), 0);
        chk("rst_min", int'(min_val), 255);
        chk("rst_max", int'(max_val), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic capture
        trig_phase = 10'd16;
        pulse(1'b1, 1'b0);
        set_ph(0);
        run(0, 1, 1'b0, -1, 400, cyc);
        chk("basic_cycles", cyc, 80);
        chk("basic_wr_count", int'(wr_count), 64);
        chk("basic_min", int'(min_val), 16);
        chk("basic_max", int'(max_val), 79);
        read_check(0, 16);
        read_check(5, 21);
        read_check(63, 79);

        // Gapped valid, with reads aimed at the write address
        pulse(1'b1, 1'b0);
        set_ph(0);
        run(1, 2, 1'b0, -1, 600, cyc);
        chk("gap_cycles", cyc, 159);
        chk("gap_min", int'(min_val), 16);
        chk("gap_max", int'(max_val), 79);
        read_check(5, 21);

        // Trigger across phase wrap
        trig_phase = 10'd1000;
        pulse(1'b1, 1'b0);
        set_ph(900);
        run(0, 1, 1'b0, -1, 400, cyc);
        chk("wrap_min", int'(min_val), 0);
        chk("wrap_max", int'(max_val), 255);
        read_check(23, 255);
        read_check(24, 0);
        read_check(0, 232);

        // Abort after 10 writes, then re-arm on the same stream
        trig_phase = 10'd16;
        pulse(1'b1, 1'b0);
        set_ph(0);
        run(0, 0, 1'b0, 10, 400, cyc);
        pulse(1'b0, 1'b1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_wr_count", int'(wr_count), 10);
        pulse(1'b1, 1'b0);
        chk("rearm_wr_count", int'(wr_count), 0);
        chk("rearm_busy", int'(busy), 1);
        run(0, 1, 1'b0, -1, 2000, cyc);
        chk("rearm_cycles", cyc, 1078);
        read_check(0, 16);
        read_check(63, 79);

        // Randomized captures: random data, random valid, collision reads
        for (int k = 0; k < 3; k++) begin
            trig_phase = 10'($urandom);
            pulse(1'b1, 1'b0);
            set_ph(int'($urandom_range(0, 1023)));
            run(2, 2, 1'b1, -1, 6000, cyc);
            for (int j = 0; j < 4; j++) begin
                int a;
                a = int'($urandom_range(0, DEPTH - 1));
                read_check(a, m_ram[a]);
            end
        end

        // Async reset between edges during capture
        trig_phase = 10'd16;
        pulse(1'b1, 1'b0);
        set_ph(0);
        run(0, 1, 1'b0, 20, 400, cyc);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_wr_count", int'(wr_count), 0);
        chk("arst_min", int'(min_val), 255);
        chk("arst_max", int'(max_val), 0);
        chk("arst_rd_valid", int'(rd_valid), 0);
        chk("arst_rd_data", int'(rd_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // arm and abort together: abort wins
        pulse(1'b1, 1'b1);
        chk("arm_abort_busy", int'(busy), 0);
        chk("arm_abort_done", int'(done), 0);
        pulse(1'b1, 1'b0);
        chk("arm_only_busy", int'(busy), 1);
        pulse(1'b0, 1'b1);
        chk("abort_idle_busy", int'(busy), 0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
